// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back path.
package regfile_wb_arbiter_pkg;

   localparam int unsigned NUM_REGS  = 16;
   localparam int unsigned WB_SEL_W  = 4;
   localparam int unsigned WB_DATA_W = 32;

   // Arbitration priority state
   typedef enum logic {
      LD_PRI  = 1'b0,
      ALU_PRI = 1'b1
   } arb_state_e;

   // 4-to-16 register select decode, shared with the register file
   function automatic logic [NUM_REGS-1:0] onehot16(input logic [WB_SEL_W-1:0] sel);
      logic [NUM_REGS-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus: ALU result path and load return path.
interface regfile_wb_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SEL_W  = 4
);

   logic              alu_valid;
   logic              alu_ready;
   logic [SEL_W-1:0]  alu_rd;
   logic [DATA_W-1:0] alu_data;

   logic              ld_valid;
   logic              ld_ready;
   logic [SEL_W-1:0]  ld_rd;
   logic [DATA_W-1:0] ld_data;

   // Requesters side
   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      input  alu_ready, ld_ready
   );

   // Arbiter side
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      output alu_ready, ld_ready
   );

endinterface

// File: rtl/regfile_wb_arbiter_starve_ctr.sv
// Saturating count of cycles the ALU lost arbitration to a load.
module wb_starve_ctr #(
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic i_clock,
   input  logic i_clear,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_tc
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(MAX_WAIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Count stalled cycles; clear wins over increment; hold at CNT_MAX
   always_ff @(posedge i_clock or posedge i_clear) begin
      if (i_clear) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Next stalled cycle is the last one the ALU may lose
   assign o_tc = (r_cnt == CNT_TC);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16 x 32 register file: load-first priority with
// a starvation guard that forces an ALU grant after MAX_WAIT lost cycles.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W   = WB_DATA_W,
   parameter int unsigned SEL_W    = WB_SEL_W,
   parameter int unsigned MAX_WAIT = 3,
   parameter bit          R0_ZERO  = 1'b0
) (
   input  logic                i_clock,
   input  logic                i_clear,
   regfile_wb_arbiter_if.slave bus,
   output logic                o_wr_en,
   output logic [SEL_W-1:0]    o_wr_sel,
   output logic [DATA_W-1:0]   o_wr_data,
   output logic [NUM_REGS-1:0] o_busy
);

   arb_state_e          r_state;
   logic                r_wr_en;
   logic [SEL_W-1:0]    r_wr_sel;
   logic [DATA_W-1:0]   r_wr_data;

   logic                w_alu_gnt;
   logic                w_ld_gnt;
   logic                w_any_gnt;
   logic                w_ctr_inc;
   logic                w_ctr_clr;
   logic                w_ctr_tc;
   logic                w_r0_drop;
   logic [SEL_W-1:0]    w_sel;
   logic [DATA_W-1:0]   w_data;
   logic [NUM_REGS-1:0] w_busy;

   // Grant decode: at most one grant, never while clear is asserted
   always_comb begin
      w_alu_gnt = 1'b0;
      w_ld_gnt  = 1'b0;
      if (!i_clear) begin
         unique case (r_state)
            LD_PRI: begin
               w_ld_gnt  = bus.ld_valid;
               w_alu_gnt = bus.alu_valid & ~bus.ld_valid;
            end
            ALU_PRI: begin
               // A withdrawn ALU request hands the slot to the load
               w_alu_gnt = bus.alu_valid;
               w_ld_gnt  = bus.ld_valid & ~bus.alu_valid;
            end
            default: begin
               w_alu_gnt = 1'b0;
               w_ld_gnt  = 1'b0;
            end
         endcase
      end
   end

   assign bus.alu_ready = w_alu_gnt;
   assign bus.ld_ready  = w_ld_gnt;
   assign w_any_gnt     = w_alu_gnt | w_ld_gnt;

   // Winner's destination and data feed the output stage
   assign w_sel     = w_alu_gnt ? bus.alu_rd : bus.ld_rd;
   assign w_data    = w_alu_gnt ? bus.alu_data : bus.ld_data;
   assign w_r0_drop = R0_ZERO && (w_sel == '0);

   // ALU lost a cycle to a load while in load-priority mode
   assign w_ctr_inc = (r_state == LD_PRI) & w_ld_gnt & bus.alu_valid;
   assign w_ctr_clr = w_alu_gnt | (r_state == ALU_PRI);

   wb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_ctr (
      .i_clock (i_clock),
      .i_clear (i_clear),
      .i_inc   (w_ctr_inc),
      .i_clr   (w_ctr_clr),
      .o_tc    (w_ctr_tc)
   );

   // Priority FSM and registered write port
   always_ff @(posedge i_clock or posedge i_clear) begin
      if (i_clear) begin
         r_state   <= LD_PRI;
         r_wr_en   <= 1'b0;
         r_wr_sel  <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_any_gnt & ~w_r0_drop;
         if (w_any_gnt) begin
            r_wr_sel  <= w_sel;
            r_wr_data <= w_data;
         end
         unique case (r_state)
            LD_PRI: begin
               if (w_ctr_inc && w_ctr_tc) begin
                  r_state <= ALU_PRI;
               end
            end
            ALU_PRI: r_state <= LD_PRI;
            default: r_state <= LD_PRI;
         endcase
      end
   end

   // Destinations that are requested or about to be written
   always_comb begin
      w_busy = '0;
      if (!i_clear) begin
         if (bus.alu_valid) begin
            w_busy = w_busy | onehot16(bus.alu_rd);
         end
         if (bus.ld_valid) begin
            w_busy = w_busy | onehot16(bus.ld_rd);
         end
         if (r_wr_en) begin
            w_busy = w_busy | onehot16(r_wr_sel);
         end
      end
   end

   assign o_wr_en   = r_wr_en;
   assign o_wr_sel  = r_wr_sel;
   assign o_wr_data = r_wr_data;
   assign o_busy    = w_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (MAX_WAIT=3, R0_ZERO=1).
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        clear;
   logic        wr_en;
   logic [3:0]  wr_sel;
   logic [31:0] wr_data;
   logic [15:0] busy;

   wr_t exp_q[$];
   int  n_cmp;
   int  n_err;

   regfile_wb_arbiter_if #(.DATA_W(32), .SEL_W(4)) bus ();

   regfile_wb_arbiter #(
      .DATA_W   (32),
      .SEL_W    (4),
      .MAX_WAIT (3),
      .R0_ZERO  (1'b1)
   ) dut (
      .i_clock   (clk),
      .i_clear   (clear),
      .bus       (bus),
      .o_wr_en   (wr_en),
      .o_wr_sel  (wr_sel),
      .o_wr_data (wr_data),
      .o_busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] sel, input logic [31:0] data);
      wr_t e;
      e.sel  = sel;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // One cycle: check readies/wr_en mid-cycle, then advance past the next edge
   task automatic cyc(input logic alu_rdy, input logic ld_rdy, input logic en, input string name);
      @(negedge clk);
      chk({name, "_alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, alu_rdy});
      chk({name, "_ld_ready"}, {31'd0, bus.ld_ready}, {31'd0, ld_rdy});
      chk({name, "_wr_en"}, {31'd0, wr_en}, {31'd0, en});
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write presented by the DUT must match the next expected one
   always @(negedge clk) begin
      if (!clear && wr_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got sel=%0d data=%h expected none", wr_sel, wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_sel", {28'd0, wr_sel}, {28'd0, e.sel});
            chk("wr_data", wr_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      clear = 1'b1;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 4'd5;
      bus.alu_data  = 32'h5555_0005;
      bus.ld_valid  = 1'b0;
      bus.ld_rd     = 4'd0;
      bus.ld_data   = 32'h0;

      // 1. Reset with a request held
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_sel", {28'd0, wr_sel}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_busy", {16'd0, busy}, 32'd0);
      chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
      chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
      @(posedge clk);
      #1;
      push(4'd5, 32'h5555_0005);
      clear = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, "rel");
      bus.alu_valid = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, "rel_wr");
      cyc(1'b0, 1'b0, 1'b0, "rel_idle");

      // 2. Single ALU write
      push(4'd3, 32'hDEAD_BEEF);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 4'd3;
      bus.alu_data  = 32'hDEAD_BEEF;
      cyc(1'b1, 1'b0, 1'b0, "t2_req");
      bus.alu_valid = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, "t2_wr");
      cyc(1'b0, 1'b0, 1'b0, "t2_idle");

      // 3. Same destination on both paths: load first, ALU last
      push(4'd7, 32'h1111_1111);
      push(4'd7, 32'h2222_2222);
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = 4'd7;
      bus.ld_data   = 32'h1111_1111;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 4'd7;
      bus.alu_data  = 32'h2222_2222;
      cyc(1'b0, 1'b1, 1'b0, "t3_c1");
      bus.ld_valid = 1'b0;
      cyc(1'b1, 1'b0, 1'b1, "t3_c2");
      bus.alu_valid = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, "t3_wr");
      cyc(1'b0, 1'b0, 1'b0, "t3_idle");

      // 4. Starvation guard: loads win cycles 1-3, ALU forced in cycle 4
      begin
         int li;
         li = 0;
         bus.alu_valid = 1'b1;
         bus.alu_rd    = 4'd12;
         bus.alu_data  = 32'hA1A1_A1A1;
         for (int c = 1; c <= 10; c++) begin
            bus.ld_valid = 1'b1;
            bus.ld_rd    = 4'(li + 1);
            bus.ld_data  = 32'h1000_0000 + 32'(li);
            if (c == 4) push(4'd12, 32'hA1A1_A1A1);
            else        push(4'(li + 1), 32'h1000_0000 + 32'(li));
            cyc(c == 4, c != 4, c != 1, $sformatf("t4_c%0d", c));
            if (c == 4) bus.alu_valid = 1'b0;
            else        li++;
         end
         bus.ld_valid = 1'b0;
         cyc(1'b0, 1'b0, 1'b1, "t4_wr");
         cyc(1'b0, 1'b0, 1'b0, "t4_idle");
      end

      // 5. r0 writes are accepted but suppressed
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 4'd0;
      bus.alu_data  = 32'd5;
      cyc(1'b1, 1'b0, 1'b0, "t5_r0");
      bus.alu_valid = 1'b0;
      push(4'd1, 32'h0000_0077);
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 4'd1;
      bus.ld_data  = 32'h0000_0077;
      cyc(1'b0, 1'b1, 1'b0, "t5_ld");
      bus.ld_valid = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, "t5_wr");
      cyc(1'b0, 1'b0, 1'b0, "t5_idle");

      // 6. busy tracking
      push(4'd2, 32'h0000_0222);
      push(4'd9, 32'h0000_0999);
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = 4'd2;
      bus.ld_data   = 32'h0000_0222;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 4'd9;
      bus.alu_data  = 32'h0000_0999;
      #1;
      chk("t6_busy_req", {16'd0, busy}, 32'h0000_0204);
      cyc(1'b0, 1'b1, 1'b0, "t6_c1");
      bus.ld_valid = 1'b0;
      chk("t6_busy_ld_out", {16'd0, busy}, 32'h0000_0204);
      cyc(1'b1, 1'b0, 1'b1, "t6_c2");
      bus.alu_valid = 1'b0;
      chk("t6_busy_alu_out", {16'd0, busy}, 32'h0000_0200);
      cyc(1'b0, 1'b0, 1'b1, "t6_wr");
      chk("t6_busy_drained", {16'd0, busy}, 32'h0000_0000);
      cyc(1'b0, 1'b0, 1'b0, "t6_idle");

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
